hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It generates stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers and the forwarding selects for the E-stage ALU operands. It sequences three things: post-reset pipeline flush, load-use interlock, and multi-cycle data-memory waits with timeout. It sits beside the datapath and drives the enable and clear pins of every pipeline register.

Parameters:
RESET_FLUSH_CYCLES, 2, cycles that FlushD/FlushE stay asserted after reset deasserts (min 1).
MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before a fault is raised; 0 disables the timeout.
TMO_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2^TMO_W.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
Rs1D, Rs2D  in  5  source registers in D
Rs1E, Rs2E, RdE  in  5  source and destination registers in E
RdM, RdW  in  5  destination registers in M and W
RegWriteM, RegWriteW  in  1  register write enables of M and W
ResultSrcE  in  2  result select of E; 2'b01 = load
PCSrcE  in  1  branch/jump taken, resolved in E
MemAccessM  in  1  load or store in M
MemReadyM  in  1  data memory completes the access this cycle
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register (insert bubble)
ForwardAE, ForwardBE  out  2  00 register file, 01 from W, 10 from M
MemFault  out  1  sticky: a memory access timed out
LoadUseCnt, MemWaitCnt, BranchFlushCnt  out  32  performance counters

Behaviour:
- Only the state, the wait counter, the init counter, MemFault and the perf counters are registered. Stall, flush and forward outputs are combinational from state and inputs.
- While reset is high:
  - state = INIT, init counter = RESET_FLUSH_CYCLES, wait counter = 0, MemFault = 0, counters = 0.
  - Outputs: FlushD = FlushE = 1, all stalls 0, FlushW = 0, forwards 00.
- INIT:
  - FlushD = FlushE = 1; all stalls 0.
  - Counter decrements each cycle; at 1, go to RUN.
  - All other inputs are ignored.
- RUN: evaluate in priority order.
  1. Memory wait. Condition: MemAccessM & ~MemReadyM.
     - Outputs: StallF/D/E/M = 1, FlushW = 1.
     - Next state MEM_WAIT, wait counter <= 1.
     - PCSrcE and load-use are suppressed this cycle.
  2. Branch taken. Condition: PCSrcE.
     - FlushD = FlushE = 1, StallF = 0.
     - Overrides load-use if both are present; this combination is architecturally impossible.
  3. Load-use. Condition: ResultSrcE == 2'b01 & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).
     - StallF = StallD = 1, FlushE = 1.
  4. Otherwise all outputs are 0.
- MEM_WAIT:
  - If MemReadyM = 1: stalls and FlushW drop in the same cycle; next state RUN; wait counter <= 0.
  - Else, if MEM_TIMEOUT != 0 and wait counter == MEM_TIMEOUT:
    - MemFault <= 1; next state RUN.
    - This cycle: stalls = 0, FlushW = 1, so the faulted access is dropped.
  - Else: StallF/D/E/M = 1, FlushW = 1, wait counter increments.
  - PCSrcE is ignored; the branch is held in E and resolves after the wait.
- Forwarding, applied independently for A (Rs1E) and B (Rs2E):
  - 10 if RegWriteM & RdM != 0 & RdM == RsxE.
  - Else 01 if RegWriteW & RdW != 0 & RdW == RsxE.
  - Else 00.
  - M takes priority over W. Forwarding is computed in all states.
- MemFault is cleared only by reset.
- Reset asserted mid-wait or mid-INIT: immediate return to INIT values, no residual stall.

Optional Feature:
HAZARD_PERF_EN.
- Defined:
  - LoadUseCnt increments on each load-use stall cycle.
  - MemWaitCnt increments on each MEM_WAIT stall cycle, including the RUN entry cycle.
  - BranchFlushCnt increments on each branch flush.
  - All three saturate at 2^32-1.
- Undefined: the counters are not built and the ports are tied to 0; the interface is unchanged.

Decomposition:
- Package hazard_pkg:
  - state enum {INIT, RUN, MEM_WAIT};
  - FWD_NONE = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - RESULT_SRC_LOAD = 2'b01.
- Sub-module forward_sel: one operand's comparator chain, instantiated twice (A and B).

Test Plan:
- Reset pulse then release, RESET_FLUSH_CYCLES = 2 -> FlushD = FlushE = 1 for exactly 2 cycles after release, then 0; all stalls 0 throughout.
- ResultSrcE = 01, RdE = 5, Rs2D = 5 -> StallF = StallD = FlushE = 1 for one cycle. Same stimulus with RdE = 0 -> no stall.
- RegWriteM = 1, RdM = 7, RegWriteW = 1, RdW = 7, Rs1E = 7 -> ForwardAE = 10. With RegWriteM = 0 -> 01. With Rs1E = 0 -> 00.
- MemAccessM = 1, MemReadyM low for 3 cycles then high -> StallF/D/E/M = FlushW = 1 for 3 cycles, 0 on the ready cycle. PCSrcE = 1 during the wait -> no FlushD.
- MEM_TIMEOUT = 4, MemReadyM held low -> stalls for 4 cycles, then stall = 0, FlushW = 1, MemFault = 1 and stays 1 until reset.
- With HAZARD_PERF_EN: 2 load-use stalls, 3 wait cycles, 1 branch -> counters read 2, 3, 1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_NONE        = 2'b00;
  localparam logic [1:0] FWD_W           = 2'b01;
  localparam logic [1:0] FWD_M           = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// Forwarding select for one E-stage ALU operand; M has priority over W.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] Forward
);

  always_comb begin
    Forward = FWD_NONE;
    if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
      Forward = FWD_M;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
      Forward = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: reset flush, load-use interlock, memory waits with timeout.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RESET_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT        = 255,
  parameter int TMO_W              = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemAccessM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemFault,
  output logic [31:0] LoadUseCnt,
  output logic [31:0] MemWaitCnt,
  output logic [31:0] BranchFlushCnt
);

  localparam int               INIT_W  = $clog2(RESET_FLUSH_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_LD = INIT_W'(RESET_FLUSH_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LIM = TMO_W'(MEM_TIMEOUT);
  localparam bit                TMO_EN  = (MEM_TIMEOUT != 0);

  state_t            state_q, state_d;
  logic [INIT_W-1:0] initCnt_q, initCnt_d;
  logic [TMO_W-1:0]  waitCnt_q, waitCnt_d;
  logic              memFault_q, memFault_d;
  logic              loadUse;
  logic [1:0]        fwdA, fwdB;

  assign loadUse = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      initCnt_q  <= INIT_LD;
      waitCnt_q  <= '0;
      memFault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      initCnt_q  <= initCnt_d;
      waitCnt_q  <= waitCnt_d;
      memFault_q <= memFault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    initCnt_d  = initCnt_q;
    waitCnt_d  = waitCnt_q;
    memFault_d = memFault_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    case (state_q)
      INIT: begin
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        initCnt_d = initCnt_q - 1'b1;
        if (initCnt_q == INIT_W'(1)) state_d = RUN;
      end
      RUN: begin
        if (MemAccessM && !MemReadyM) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW    = 1'b1;
          state_d   = MEM_WAIT;
          waitCnt_d = TMO_W'(1);
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (loadUse) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A branch sitting in E is held here and resolves once the wait ends.
        if (MemReadyM) begin
          state_d   = RUN;
          waitCnt_d = '0;
        end else if (TMO_EN && (waitCnt_q == TMO_LIM)) begin
          memFault_d = 1'b1;
          FlushW     = 1'b1;
          state_d    = RUN;
          waitCnt_d  = '0;
        end else begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW    = 1'b1;
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  forward_sel u_fwdA (
    .RsE(Rs1E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Forward(fwdA)
  );

  forward_sel u_fwdB (
    .RsE(Rs2E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Forward(fwdB)
  );

  assign ForwardAE = reset ? FWD_NONE : fwdA;
  assign ForwardBE = reset ? FWD_NONE : fwdB;
  assign MemFault  = memFault_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] luCnt_q, mwCnt_q, brCnt_q;
  logic        luEv, mwEv, brEv;

  // Events are decoded from the control outputs so they match exactly what the pipeline saw.
  assign luEv = (state_q == RUN) && StallD && !StallE;
  assign mwEv = StallM;
  assign brEv = (state_q == RUN) && FlushD && !StallD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      luCnt_q <= '0;
      mwCnt_q <= '0;
      brCnt_q <= '0;
    end else begin
      if (luEv && (luCnt_q != '1)) luCnt_q <= luCnt_q + 32'd1;
      if (mwEv && (mwCnt_q != '1)) mwCnt_q <= mwCnt_q + 32'd1;
      if (brEv && (brCnt_q != '1)) brCnt_q <= brCnt_q + 32'd1;
    end
  end

  assign LoadUseCnt     = luCnt_q;
  assign MemWaitCnt     = mwCnt_q;
  assign BranchFlushCnt = brCnt_q;
`else
  assign LoadUseCnt     = '0;
  assign MemWaitCnt     = '0;
  assign BranchFlushCnt = '0;
`endif

endmodule
